// File: rtl/dispatch_router_if.sv
// Decoder/ROB/station-facing bus of the dispatch router.
// The router uses the slave modport; the surrounding design drives the master side.
interface dispatch_router_if #(
  parameter int TAG_W = 4
);
  logic             i_valid;
  logic             o_ready;
  logic [8:0]       i_pc;
  logic [4:0]       i_rs1, i_rs2, i_rd;
  logic             i_alusrc, i_branch, i_memread, i_memwrite, i_regwrite;
  logic [31:0]      i_imm;
  logic [3:0]       i_aluop;
  logic [1:0]       i_futype;
  logic             rob_ready;
  logic             alu_valid, alu_ready;
  logic             br_valid, br_ready;
  logic             lsu_valid, lsu_ready;
  logic [8:0]       o_pc;
  logic [4:0]       o_rs1, o_rs2, o_rd;
  logic             o_alusrc, o_branch, o_memread, o_memwrite, o_regwrite;
  logic [31:0]      o_imm;
  logic [3:0]       o_aluop;
  logic [TAG_W-1:0] o_tag;

  modport slave (
    input  i_valid, i_pc, i_rs1, i_rs2, i_rd, i_alusrc, i_branch, i_memread,
           i_memwrite, i_regwrite, i_imm, i_aluop, i_futype, rob_ready,
           alu_ready, br_ready, lsu_ready,
    output o_ready, alu_valid, br_valid, lsu_valid, o_pc, o_rs1, o_rs2, o_rd,
           o_alusrc, o_branch, o_memread, o_memwrite, o_regwrite, o_imm,
           o_aluop, o_tag
  );

  modport master (
    output i_valid, i_pc, i_rs1, i_rs2, i_rd, i_alusrc, i_branch, i_memread,
           i_memwrite, i_regwrite, i_imm, i_aluop, i_futype, rob_ready,
           alu_ready, br_ready, lsu_ready,
    input  o_ready, alu_valid, br_valid, lsu_valid, o_pc, o_rs1, o_rs2, o_rd,
           o_alusrc, o_branch, o_memread, o_memwrite, o_regwrite, o_imm,
           o_aluop, o_tag
  );
endinterface

// File: rtl/dispatch_router.sv
// In-order dispatch FIFO: steers the oldest micro-op to the ALU, branch or LSU
// station by FU type and stamps each dispatched op with a wrapping tag.
module dispatch_router #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input logic              clk,
  input logic              reset_n,
  input logic              flush,
  dispatch_router_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [8:0]  pc;
    logic [4:0]  rs1, rs2, rd;
    logic        alusrc, branch, memread, memwrite, regwrite;
    logic [31:0] imm;
    logic [3:0]  aluop;
    logic [1:0]  futype;
  } uop_t;

  uop_t             mem [DEPTH];
  logic [AW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic [TAG_W-1:0] tag_q;
  uop_t             head, wr_uop;
  logic             can_go, is_br, is_lsu, is_alu, enq, fire;

  always_comb begin
    wr_uop          = '0;
    wr_uop.pc       = bus.i_pc;
    wr_uop.rs1      = bus.i_rs1;
    wr_uop.rs2      = bus.i_rs2;
    wr_uop.rd       = bus.i_rd;
    wr_uop.alusrc   = bus.i_alusrc;
    wr_uop.branch   = bus.i_branch;
    wr_uop.memread  = bus.i_memread;
    wr_uop.memwrite = bus.i_memwrite;
    wr_uop.regwrite = bus.i_regwrite;
    wr_uop.imm      = bus.i_imm;
    wr_uop.aluop    = bus.i_aluop;
    wr_uop.futype   = bus.i_futype;
  end

  assign head = mem[head_q];

  // Valids never look at station readies; futype 11 falls through to the ALU.
  assign can_go = (count_q != '0) && bus.rob_ready && !flush;
  assign is_br  = (head.futype == 2'b01);
  assign is_lsu = (head.futype == 2'b10);
  assign is_alu = !is_br && !is_lsu;

  assign bus.alu_valid = can_go && is_alu;
  assign bus.br_valid  = can_go && is_br;
  assign bus.lsu_valid = can_go && is_lsu;
  assign bus.o_ready   = (count_q < CW'(DEPTH));

  assign fire = (bus.alu_valid && bus.alu_ready) ||
                (bus.br_valid  && bus.br_ready)  ||
                (bus.lsu_valid && bus.lsu_ready);
  assign enq  = bus.i_valid && bus.o_ready;

  assign bus.o_pc       = head.pc;
  assign bus.o_rs1      = head.rs1;
  assign bus.o_rs2      = head.rs2;
  assign bus.o_rd       = head.rd;
  assign bus.o_alusrc   = head.alusrc;
  assign bus.o_branch   = head.branch;
  assign bus.o_memread  = head.memread;
  assign bus.o_memwrite = head.memwrite;
  assign bus.o_regwrite = head.regwrite;
  assign bus.o_imm      = head.imm;
  assign bus.o_aluop    = head.aluop;
  assign bus.o_tag      = tag_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      tag_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Storage is left as-is; only the bookkeeping is cleared.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      tag_q   <= '0;
    end else begin
      if (enq) begin
        mem[tail_q] <= wr_uop;
        tail_q      <= tail_q + 1'b1;
      end
      if (fire) begin
        head_q <= head_q + 1'b1;
        tag_q  <= tag_q + 1'b1;
      end
      case ({enq, fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
